// File: rtl/traffic_pkg.sv
// Shared lamp/phase encodings and small elaboration helpers for the
// N-approach traffic light controller.
package traffic_pkg;

  typedef enum logic [1:0] {
    LT_RED    = 2'b00,
    LT_YELLOW = 2'b01,
    LT_GREEN  = 2'b10
  } light_t;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_GREEN   = 2'd1,
    PH_YELLOW  = 2'd2,
    PH_ALL_RED = 2'd3
  } phase_t;

  // Raw lamp codes driven onto the per-approach 2-bit lamp buses
  localparam logic [1:0] LAMP_RED    = LT_RED;
  localparam logic [1:0] LAMP_YELLOW = LT_YELLOW;
  localparam logic [1:0] LAMP_GREEN  = LT_GREEN;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic dir_valid(input int unsigned dir, input int unsigned n_dir);
    return dir < n_dir;
  endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin arbiter with an overriding preempt request.
// The search starts one past the last-served pointer.
module rr_arbiter_n
  import traffic_pkg::*;
#(
  parameter  int unsigned N_DIR = 3,
  localparam int unsigned IDX_W = $clog2(N_DIR)
) (
  input  logic [N_DIR-1:0] req,
  input  logic [IDX_W-1:0] pointer,
  input  logic             preempt,
  input  logic [IDX_W-1:0] preempt_dir,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0]   start_c;
  logic [2*N_DIR-1:0] dbl_c;
  logic [N_DIR-1:0]   rot_c;
  logic               pre_ok_c;

  assign pre_ok_c = preempt && dir_valid(32'(preempt_dir), N_DIR);
  assign start_c  = (32'(pointer) >= N_DIR - 1) ? '0 : pointer + IDX_W'(1);

  // Rotate requests so bit 0 is the first approach searched
  assign dbl_c = {req, req};
  assign rot_c = N_DIR'(dbl_c >> start_c);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (pre_ok_c) begin
      grant_valid = 1'b1;
      grant_idx   = preempt_dir;
    end else begin
      for (int j = int'(N_DIR) - 1; j >= 0; j--) begin
        if (rot_c[j]) begin
          grant_valid = 1'b1;
          grant_idx   = IDX_W'((32'(start_c) + 32'(j)) % N_DIR);
        end
      end
    end
  end

endmodule

// File: rtl/traffic_light_controller_n.sv
// N-approach traffic light controller: round-robin service of sensor demand
// with green min/gap-out/max-out timing, yellow and all-red clearance, and preemption.
module traffic_light_controller_n
  import traffic_pkg::*;
#(
  parameter  int unsigned N_DIR       = 3,
  parameter  int unsigned GREEN_MIN   = 3,
  parameter  int unsigned GREEN_HOLD  = 5,
  parameter  int unsigned GREEN_MAX   = 10,
  parameter  int unsigned YELLOW_CYC  = 2,
  parameter  int unsigned ALL_RED_CYC = 1,
  localparam int unsigned IDX_W       = $clog2(N_DIR)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_DIR-1:0]      sensor,
  input  logic                  preempt,
  input  logic [IDX_W-1:0]      preempt_dir,
  output logic [N_DIR-1:0][1:0] lights,
  output logic [IDX_W-1:0]      active_dir,
  output logic [1:0]            phase
);

  localparam int unsigned CNT_MAX = max_u(max_u(max_u(GREEN_MIN, GREEN_HOLD), GREEN_MAX),
                                          max_u(YELLOW_CYC, ALL_RED_CYC));
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(GREEN_HOLD);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YEL_C  = CNT_W'(YELLOW_CYC);
  localparam logic [CNT_W-1:0] AR_C   = CNT_W'(ALL_RED_CYC);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  phase_t                  phase_q, phase_d;
  logic [IDX_W-1:0]        act_q, act_d;
  logic [IDX_W-1:0]        ptr_q, ptr_d;
  logic [CNT_W-1:0]        green_q, green_d;
  logic [CNT_W-1:0]        gap_q, gap_d;
  logic [CNT_W-1:0]        tmr_q, tmr_d;
  logic [N_DIR-1:0][1:0]   lights_q, lights_d;

  logic                    grant_valid;
  logic [IDX_W-1:0]        grant_idx;
  logic                    own_c, other_c;
  logic                    pre_ok_c, pre_own_c;
  logic                    gap_out_c, max_out_c, green_exit_c;

  rr_arbiter_n #(
    .N_DIR (N_DIR)
  ) u_arb (
    .req         (sensor),
    .pointer     (ptr_q),
    .preempt     (preempt),
    .preempt_dir (preempt_dir),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Split demand into the served approach and everyone else
  always_comb begin
    own_c   = 1'b0;
    other_c = 1'b0;
    for (int i = 0; i < int'(N_DIR); i++) begin
      if (act_q == IDX_W'(i)) own_c = sensor[i];
      else                    other_c = other_c | sensor[i];
    end
  end

  assign pre_ok_c     = preempt && dir_valid(32'(preempt_dir), N_DIR);
  assign pre_own_c    = pre_ok_c && (preempt_dir == act_q);
  assign gap_out_c    = (gap_q == HOLD_C);
  assign max_out_c    = (green_q == MAX_C) && other_c;
  assign green_exit_c = !pre_own_c && (green_q >= MIN_C) && (gap_out_c || max_out_c);

  // Next-state, timers and next lamp pattern
  always_comb begin
    phase_d  = phase_q;
    act_d    = act_q;
    ptr_d    = ptr_q;
    green_d  = green_q;
    gap_d    = gap_q;
    tmr_d    = tmr_q;
    lights_d = '0;

    case (phase_q)
      PH_IDLE: begin
        if (grant_valid) begin
          phase_d = PH_GREEN;
          act_d   = grant_idx;
          green_d = ONE_C;
          gap_d   = '0;
          tmr_d   = '0;
          if (!pre_ok_c) ptr_d = grant_idx;
        end
      end

      PH_GREEN: begin
        if ((pre_ok_c && !pre_own_c) || green_exit_c) begin
          phase_d = PH_YELLOW;
          tmr_d   = ONE_C;
          green_d = '0;
          gap_d   = '0;
        end else begin
          green_d = (green_q == MAX_C) ? green_q : green_q + ONE_C;
          if (own_c)                gap_d = '0;
          else if (gap_q != HOLD_C) gap_d = gap_q + ONE_C;
        end
      end

      PH_YELLOW: begin
        if (tmr_q >= YEL_C) begin
          phase_d = PH_ALL_RED;
          tmr_d   = ONE_C;
        end else begin
          tmr_d = tmr_q + ONE_C;
        end
      end

      PH_ALL_RED: begin
        if (tmr_q >= AR_C) begin
          tmr_d   = '0;
          green_d = '0;
          gap_d   = '0;
          if (grant_valid) begin
            phase_d = PH_GREEN;
            act_d   = grant_idx;
            green_d = ONE_C;
            if (!pre_ok_c) ptr_d = grant_idx;
          end else begin
            phase_d = PH_IDLE;
          end
        end else begin
          tmr_d = tmr_q + ONE_C;
        end
      end

      default: phase_d = PH_IDLE;
    endcase

    for (int i = 0; i < int'(N_DIR); i++) begin
      lights_d[i] = LAMP_RED;
      if (act_d == IDX_W'(i)) begin
        if (phase_d == PH_GREEN)       lights_d[i] = LAMP_GREEN;
        else if (phase_d == PH_YELLOW) lights_d[i] = LAMP_YELLOW;
      end
    end
  end

  // State register; pointer resets to the last approach so index 0 wins first
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= PH_IDLE;
      act_q    <= '0;
      ptr_q    <= IDX_W'(N_DIR - 1);
      green_q  <= '0;
      gap_q    <= '0;
      tmr_q    <= '0;
      lights_q <= '0;
    end else begin
      phase_q  <= phase_d;
      act_q    <= act_d;
      ptr_q    <= ptr_d;
      green_q  <= green_d;
      gap_q    <= gap_d;
      tmr_q    <= tmr_d;
      lights_q <= lights_d;
    end
  end

  assign lights     = lights_q;
  assign active_dir = act_q;
  assign phase      = phase_q;

endmodule

// File: tb/tb_traffic_light_controller_n.sv
// Directed self-checking bench for traffic_light_controller_n with default timing
// (3 approaches, min 3, hold 5, max 10, yellow 2, all-red 1).
module tb_traffic_light_controller_n;

  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_GRN  = 2'd1;
  localparam logic [1:0] P_YEL  = 2'd2;
  localparam logic [1:0] P_AR   = 2'd3;
  localparam logic [1:0] L_G    = 2'b10;
  localparam logic [1:0] L_Y    = 2'b01;

  logic            clk;
  logic            reset;
  logic [2:0]      sensor;
  logic            preempt;
  logic [1:0]      preempt_dir;
  logic [2:0][1:0] lights;
  logic [1:0]      active_dir;
  logic [1:0]      phase;

  int total;
  int passed;

  traffic_light_controller_n #(
    .N_DIR       (3),
    .GREEN_MIN   (3),
    .GREEN_HOLD  (5),
    .GREEN_MAX   (10),
    .YELLOW_CYC  (2),
    .ALL_RED_CYC (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sensor      (sensor),
    .preempt     (preempt),
    .preempt_dir (preempt_dir),
    .lights      (lights),
    .active_dir  (active_dir),
    .phase       (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected lamp vector: one approach in colour c, the rest red
  function automatic logic [5:0] lv(input int d, input logic [1:0] c);
    return 6'(c) << (2 * d);
  endfunction

  task automatic expect_state(input string tag, input logic [5:0] l, input logic [1:0] p,
                              input logic [1:0] d);
    chk({tag, ".lights"}, 32'(lights), 32'(l));
    chk({tag, ".phase"}, 32'(phase), 32'(p));
    chk({tag, ".dir"}, 32'(active_dir), 32'(d));
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    sensor      = '0;
    preempt     = 1'b0;
    preempt_dir = '0;
    tick();
    reset       = 1'b0;
  endtask

  initial begin
    int pos;
    int d;
    total       = 0;
    passed      = 0;
    reset       = 1'b1;
    sensor      = '0;
    preempt     = 1'b0;
    preempt_dir = '0;
    tick();
    tick();
    expect_state("rst", 6'd0, P_IDLE, 2'd0);

    // Out-of-range preempt direction is ignored
    reset       = 1'b0;
    preempt     = 1'b1;
    preempt_dir = 2'd3;
    tick();
    expect_state("badpre1", 6'd0, P_IDLE, 2'd0);
    tick();
    expect_state("badpre2", 6'd0, P_IDLE, 2'd0);
    preempt = 1'b0;

    // Gap-out, single approach
    sensor = 3'b001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 3) sensor = 3'b000;
      expect_state($sformatf("gap.g%0d", i), lv(0, L_G), P_GRN, 2'd0);
    end
    tick(); expect_state("gap.y1", lv(0, L_Y), P_YEL, 2'd0);
    tick(); expect_state("gap.y2", lv(0, L_Y), P_YEL, 2'd0);
    tick(); expect_state("gap.ar", 6'd0, P_AR, 2'd0);
    tick(); expect_state("gap.idle", 6'd0, P_IDLE, 2'd0);

    // Max-out handover 0 -> 2
    do_reset();
    sensor = 3'b101;
    for (int i = 1; i <= 10; i++) begin
      tick();
      expect_state($sformatf("max.g%0d", i), lv(0, L_G), P_GRN, 2'd0);
    end
    tick(); expect_state("max.y1", lv(0, L_Y), P_YEL, 2'd0);
    tick(); expect_state("max.y2", lv(0, L_Y), P_YEL, 2'd0);
    tick(); expect_state("max.ar", 6'd0, P_AR, 2'd0);
    tick(); expect_state("max.g2a", lv(2, L_G), P_GRN, 2'd2);
    tick(); expect_state("max.g2b", lv(2, L_G), P_GRN, 2'd2);

    // Fairness with all approaches demanding
    do_reset();
    sensor = 3'b111;
    for (int j = 1; j <= 60; j++) begin
      tick();
      pos = (j - 1) % 13;
      d   = ((j - 1) / 13) % 3;
      if (pos < 10)
        expect_state($sformatf("fair.c%0d", j), lv(d, L_G), P_GRN, 2'(d));
      else if (pos < 12)
        expect_state($sformatf("fair.c%0d", j), lv(d, L_Y), P_YEL, 2'(d));
      else
        expect_state($sformatf("fair.c%0d", j), 6'd0, P_AR, 2'(d));
    end

    // Hold with no competitor, then gap-out after release
    do_reset();
    sensor = 3'b010;
    for (int i = 1; i <= 36; i++) begin
      tick();
      if (i == 31) sensor = 3'b000;
      expect_state($sformatf("hold.g%0d", i), lv(1, L_G), P_GRN, 2'd1);
    end
    tick(); expect_state("hold.y1", lv(1, L_Y), P_YEL, 2'd1);

    // Preempt ignores GREEN_MIN, then holds its own green
    do_reset();
    sensor = 3'b001;
    tick(); expect_state("pre.g0", lv(0, L_G), P_GRN, 2'd0);
    sensor      = 3'b011;
    preempt     = 1'b1;
    preempt_dir = 2'd2;
    tick(); expect_state("pre.y1", lv(0, L_Y), P_YEL, 2'd0);
    tick(); expect_state("pre.y2", lv(0, L_Y), P_YEL, 2'd0);
    tick(); expect_state("pre.ar", 6'd0, P_AR, 2'd0);
    for (int i = 5; i <= 15; i++) begin
      tick();
      expect_state($sformatf("pre.g2_%0d", i), lv(2, L_G), P_GRN, 2'd2);
    end
    preempt = 1'b0;
    tick(); expect_state("pre.rel.y1", lv(2, L_Y), P_YEL, 2'd2);
    tick(); expect_state("pre.rel.y2", lv(2, L_Y), P_YEL, 2'd2);
    tick(); expect_state("pre.rel.ar", 6'd0, P_AR, 2'd2);
    // Pointer was untouched by the preempt grant, so search resumes after 0
    tick(); expect_state("pre.rr", lv(1, L_G), P_GRN, 2'd1);

    // Approach 1 gaps out; reset lands in its first yellow cycle
    sensor = 3'b001;
    for (int i = 20; i <= 24; i++) begin
      tick();
      expect_state($sformatf("ry.g%0d", i), lv(1, L_G), P_GRN, 2'd1);
    end
    tick(); expect_state("ry.y1", lv(1, L_Y), P_YEL, 2'd1);
    reset  = 1'b1;
    sensor = 3'b110;
    tick(); expect_state("ry.rst", 6'd0, P_IDLE, 2'd0);
    reset = 1'b0;
    tick(); expect_state("ry.grant", lv(1, L_G), P_GRN, 2'd1);
    tick(); expect_state("ry.hold", lv(1, L_G), P_GRN, 2'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller_n.md
Name: traffic_light_controller_n

Overview:
Parametrised successor to the fixed three-approach intersection controller. It serves N_DIR sensor-driven approaches with round-robin fairness and configurable green-minimum, gap-out, max-out, yellow and all-red timing. It adds emergency preemption. It sits between the sensor inputs and the per-approach 2-bit lamp drivers.

Parameters:
N_DIR, 3, number of approaches (2..8); index 0 has highest priority out of reset
GREEN_MIN, 3, minimum green cycles before any non-preempt exit
GREEN_HOLD, 5, consecutive cycles with own sensor low (while green) before gap-out
GREEN_MAX, 10, green cycles after which a competing request forces max-out
YELLOW_CYC, 2, yellow duration in cycles (>=1)
ALL_RED_CYC, 1, all-red clearance after yellow (>=1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
sensor  in  N_DIR  per-approach demand, level-sensitive, sampled each edge
preempt  in  1  emergency request, level-sensitive
preempt_dir  in  $clog2(N_DIR)  approach to grant on preempt; values >= N_DIR are ignored
lights  out  N_DIR x 2  per-approach lamp: 00 red, 01 yellow, 10 green, 11 never driven
active_dir  out  $clog2(N_DIR)  approach currently green or yellow (last served while red)
phase  out  2  0 IDLE, 1 GREEN, 2 YELLOW, 3 ALL_RED

Behaviour:
- Clock is clk. Reset is synchronous, active-high, and overrides all other inputs, including mid-phase.
- Reset values: lights all 00, phase IDLE, active_dir 0, counters 0. RR pointer set so approach 0 wins first.
- All outputs are registered. At most one approach is non-red in any cycle; 11 is never output.
- IDLE:
  - All red.
  - If any valid request (sensor bit or preempt), the next cycle is GREEN for the winner.
  - Latency is one edge from sample to green.
- Arbitration:
  - Valid preempt wins over sensors.
  - Otherwise round-robin: search starts at (last served + 1) mod N_DIR.
  - The pointer updates only on a non-preempt grant.
- GREEN:
  - green_cnt counts green cycles, saturating at GREEN_MAX.
  - gap_cnt counts consecutive green cycles with own sensor low. It clears when own sensor is high.
  - Exit to YELLOW when green_cnt >= GREEN_MIN and either:
    - (a) gap_cnt == GREEN_HOLD (gap-out), or
    - (b) green_cnt == GREEN_MAX and another sensor is high (max-out).
  - If own sensor stays high with no other demand, green holds indefinitely.
  - If gap-out and max-out conditions coincide, the transition is a single exit to YELLOW.
- Preempt in GREEN:
  - If preempt is valid and preempt_dir != active_dir, exit to YELLOW next cycle, ignoring GREEN_MIN.
  - If preempt_dir == active_dir, green holds; gap-out and max-out are suppressed while preempt stays high.
- YELLOW: lasts exactly YELLOW_CYC cycles, then ALL_RED. Preempt does not truncate yellow.
- ALL_RED:
  - Lasts exactly ALL_RED_CYC cycles.
  - On the last cycle, arbitrate: if any request, go GREEN for the winner; else go IDLE.
  - The same approach may be re-granted if it is the only requester.
- Counters are $clog2(max param + 1) bits wide and never wrap.

Decomposition:
- Shared package traffic_pkg:
  - light_t enum: RED=2'b00, YELLOW=2'b01, GREEN=2'b10
  - phase_t enum: IDLE, GREEN, YELLOW, ALL_RED
  - light-encoding constants
- One sub-module, rr_arbiter_n:
  - Inputs: req[N_DIR], pointer, preempt/preempt_dir
  - Outputs: grant_valid, grant_idx (combinational)
- The FSM and timers remain in the top module.

Test Plan:
- Gap-out, single approach: reset 2 cycles, sensor[0]=1 for 3 cycles then 0 -> approach 0 green 8 cycles (3 + GREEN_HOLD 5), yellow 2, red; phase returns to IDLE after 1 all-red cycle.
- Max-out handover: sensor[0] and sensor[2] held high -> approach 0 green exactly 10 cycles, yellow 2, all-red 1, then approach 2 green; approach 1 never lit.
- Fairness: all sensors held high for 60 cycles -> green order 0,1,2,0,... with each green exactly 10 cycles; never two non-red lamps at once.
- Hold, no competitor: sensor[1] held high alone for 30 cycles -> approach 1 green for all 30 cycles with no yellow; it gaps out 5 cycles after release.
- Preempt: approach 0 green at cycle 1 of green, preempt=1 with preempt_dir=2 -> yellow next cycle (GREEN_MIN ignored), 2 yellow, 1 all-red, approach 2 green and held while preempt=1.
- Reset mid-yellow: assert reset during the first yellow cycle -> next edge gives lights all 00, phase IDLE, active_dir 0; the post-reset grant goes to the lowest-index requester.
